// File: rtl/pipe_add_pkg.sv
// -----------------------------------------------------------------------------
// pipe_add_pkg
//   Shared definitions for the pipelined ripple-carry adder:
//     - default WIDTH / STAGES values
//     - slice_w(): bits handled by one pipeline stage
//     - stage_ctl_t: per-stage control payload (valid flag + carry to next slice)
// -----------------------------------------------------------------------------
package pipe_add_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // Control part of each stage register. The data part (finished low
    // slices and still-pending operand slices) changes width from stage to
    // stage, so it lives in the generate block beside this struct.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    // Slice width per stage. A zero or negative stage count is caught by
    // the elaboration check in the top; returning WIDTH keeps the
    // expression defined until that check fires.
    function automatic int slice_w(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

endpackage : pipe_add_pkg

// File: rtl/rca_slice.sv
// -----------------------------------------------------------------------------
// rca_slice
//   Purely combinational ripple-carry adder over SLICE_W bits, built from
//   full-adder cells. One instance per pipeline stage.
//
// Ports
//   a, b   in   SLICE_W  operand slices
//   cin    in   1        carry into bit 0 of the slice
//   sum    out  SLICE_W  slice sum
//   cout   out  1        carry out of the slice MSB
// -----------------------------------------------------------------------------
module rca_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic w_carry;

    // NOTE: blocking assignments let w_carry ripple from cell to cell within
    // one evaluation; every output gets a value before use, so no latch forms.
    always_comb begin
        w_carry = cin;
        sum     = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule : rca_slice

// File: rtl/pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// pipelined_rca_adder
//   Streaming adder computing in_a + in_b + in_cin modulo 2^WIDTH. WIDTH is cut
//   into STAGES equal slices; stage k ripples slice k and registers the partial
//   sum, the slice carry, and the operand slices not yet consumed. Valid/ready
//   handshakes on both sides; one add per cycle at full throughput, latency
//   STAGES cycles.
//
// Parameters
//   WIDTH   operand/sum width, multiple of STAGES
//   STAGES  pipeline depth (1..WIDTH)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset (deassert synchronously)
//   in_valid   in   1      operands present
//   in_ready   out  1      operands accepted this cycle (combinational)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry into bit 0
//   out_valid  out  1      result present
//   out_ready  in   1      downstream accepts the result this cycle
//   out_sum    out  WIDTH  sum modulo 2^WIDTH
//   out_cout   out  1      carry out of bit WIDTH-1
//   out_ovf    out  1      signed overflow
//
// Build option
//   PIPE_ADD_OVF_EN  when defined, out_ovf reports two's-complement overflow,
//                    registered with the final stage; otherwise it is tied 0
//                    and no flop is built for it.
// -----------------------------------------------------------------------------
module pipelined_rca_adder
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SLICE_W = slice_w(WIDTH, STAGES);
    localparam int LAST    = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    // -------------------------------------------------------------------------
    // Stage k: consumes the low slice of the operands handed to it, appends the
    // slice sum above the slices finished upstream, and passes the remaining
    // operand bits on. Register widths therefore grow (sum) and shrink
    // (operands) along the pipe, and every stored bit is used downstream.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_BIT = k * SLICE_W;
        localparam int UP_W   = WIDTH - LO_BIT;     // operand bits arriving here
        localparam int DONE_W = LO_BIT + SLICE_W;   // sum bits known after here

        logic               w_up_valid;
        logic               w_up_carry;
        logic [UP_W-1:0]    w_up_a;
        logic [UP_W-1:0]    w_up_b;
        logic [SLICE_W-1:0] w_slice_sum;
        logic               w_slice_cout;
        logic               w_down_rdy;
        logic               w_rdy;
        logic               w_load;

        stage_ctl_t         r_ctl;
        logic [DONE_W-1:0]  r_sum;

        // A stage may advance when it is empty or its contents move on this
        // cycle; this lets bubbles collapse while the output is stalled.
        assign w_rdy  = !r_ctl.valid || w_down_rdy;
        assign w_load = w_rdy && w_up_valid;

        if (k == LAST) begin : g_tail
            assign w_down_rdy = out_ready;
        end else begin : g_fwd
            assign w_down_rdy = g_stage[k+1].w_rdy;
        end

        rca_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .a    (w_up_a[SLICE_W-1:0]),
            .b    (w_up_b[SLICE_W-1:0]),
            .cin  (w_up_carry),
            .sum  (w_slice_sum),
            .cout (w_slice_cout)
        );

        // NOTE: state is updated with non-blocking assignments so each stage
        // samples its upstream neighbour's value from before the clock edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctl <= '0;
            end else if (w_rdy) begin
                r_ctl.valid <= w_up_valid;
                if (w_up_valid) begin
                    r_ctl.carry <= w_slice_cout;
                end
            end
        end

        if (k == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_carry = in_cin;
            assign w_up_a     = in_a;
            assign w_up_b     = in_b;

            // NOTE: data registers are reset as well, so out_sum reads 0 out of
            // reset; they only load on an accepted transfer and otherwise hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                end else if (w_load) begin
                    r_sum <= w_slice_sum;
                end
            end
        end else begin : g_body
            assign w_up_valid = g_stage[k-1].r_ctl.valid;
            assign w_up_carry = g_stage[k-1].r_ctl.carry;
            assign w_up_a     = g_stage[k-1].g_pend.r_a;
            assign w_up_b     = g_stage[k-1].g_pend.r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                end else if (w_load) begin
                    r_sum <= {w_slice_sum, g_stage[k-1].r_sum};
                end
            end
        end

        // Operand bits above this slice ride along to the next stage; the last
        // stage has nothing left to forward.
        if (k < LAST) begin : g_pend
            logic [UP_W-SLICE_W-1:0] r_a;
            logic [UP_W-SLICE_W-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load) begin
                    r_a <= w_up_a[UP_W-1:SLICE_W];
                    r_b <= w_up_b[UP_W-1:SLICE_W];
                end
            end
        end
    end

    assign in_ready  = g_stage[0].w_rdy;
    assign out_valid = g_stage[LAST].r_ctl.valid;
    assign out_sum   = g_stage[LAST].r_sum;
    assign out_cout  = g_stage[LAST].r_ctl.carry;

`ifdef PIPE_ADD_OVF_EN
    // The top slice of a and b arrives at the last stage with the data, so the
    // sign bits of both operands and of the sum are all visible right there.
    logic w_a_msb;
    logic w_b_msb;
    logic w_s_msb;
    logic w_ovf;
    logic r_ovf;

    assign w_a_msb = g_stage[LAST].w_up_a[SLICE_W-1];
    assign w_b_msb = g_stage[LAST].w_up_b[SLICE_W-1];
    assign w_s_msb = g_stage[LAST].w_slice_sum[SLICE_W-1];
    assign w_ovf   = (w_a_msb == w_b_msb) && (w_s_msb != w_a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (g_stage[LAST].w_load) begin
            r_ovf <= w_ovf;
        end
    end

    assign out_ovf = r_ovf;
`else
    assign out_ovf = 1'b0;
`endif

endmodule : pipelined_rca_adder

// File: tb/tb_pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_rca_adder
//   Bench for pipelined_rca_adder at WIDTH=32, STAGES=4. Expected results come
//   from plain integer arithmetic on each accepted operand set, held in a FIFO
//   in acceptance order. Honours PIPE_ADD_OVF_EN when defined.
// -----------------------------------------------------------------------------
module tb_pipelined_rca_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    // {cout, ovf, sum}
    typedef logic [WIDTH+1:0] res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int   n_checks      = 0;
    int   n_fail        = 0;
    int   n_in          = 0;
    int   n_out         = 0;
    int   n_stall       = 0;
    int   cyc           = 0;
    int   mark_out      = -1;
    int   first_out_cyc = 0;
    int   last_out_cyc  = 0;
    res_t last_out      = '0;
    res_t sb[$];

    pipelined_rca_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d outputs required completion", n_out);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision integer addition, then split into fields.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
        logic [WIDTH:0] full;
        logic           ovf;
`ifdef PIPE_ADD_OVF_EN
        longint         s;
`endif
        full = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        ovf  = 1'b0;
`ifdef PIPE_ADD_OVF_EN
        s   = longint'(signed'(a)) + longint'(signed'(b)) + longint'(cin);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
        return {full[WIDTH], ovf, full[WIDTH-1:0]};
    endfunction

    // One clock: handshakes are evaluated at the falling edge, inputs are
    // changed by the caller just after the rising edge.
    task automatic step();
        res_t e;
        res_t got;
        @(negedge clk);
        cyc++;
        if (out_valid && out_ready) begin
            got = {out_cout, out_ovf, out_sum};
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(got), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                check("result", 64'(got), 64'(e));
            end
            if (n_out == mark_out) first_out_cyc = cyc;
            last_out_cyc = cyc;
            last_out     = got;
            n_out++;
        end
        if (in_valid && in_ready) begin
            sb.push_back(model(in_a, in_b, in_cin));
            n_in++;
        end
        if (in_valid && !in_ready) n_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c, output res_t got);
        int base_o;
        int guard;
        in_a      = a;
        in_b      = b;
        in_cin    = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        base_o    = n_out;
        guard     = 0;
        step();
        in_valid = 1'b0;
        while (n_out == base_o && guard < 20) begin
            step();
            guard++;
        end
        if (n_out == base_o) check("send_timeout", 64'd0, 64'd1);
        got = last_out;
    endtask

    initial begin
        int   base_i;
        int   base_o;
        int   guard;
        int   lat;
        int   prev;
        bit   pending;
        res_t held;
        res_t got;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: carry through all slices, latency
        in_a      = 32'hFFFF_FFFF;
        in_b      = 32'h0000_0001;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("t1_latency", 64'(lat),      64'd4);
        check("t1_sum",     64'(out_sum),  64'h0);
        check("t1_cout",    64'(out_cout), 64'd1);
        check("t1_ovf",     64'(out_ovf),  64'd0);
        step();

        // 2: 100 back-to-back adds, no backpressure
        mark_out = n_out;
        base_o   = n_out;
        prev     = n_stall;
        for (int i = 0; i < 100; i++) begin
            in_a     = $urandom;
            in_b     = $urandom;
            in_cin   = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        guard = 0;
        while (n_out - base_o < 100 && guard < 20) begin
            step();
            guard++;
        end
        check("t2_count",  64'(n_out - base_o),                     64'd100);
        check("t2_consec", 64'(last_out_cyc - first_out_cyc + 1),   64'd100);
        check("t2_stalls", 64'(n_stall - prev),                      64'd0);

        // 3: fill with output stalled, hold, overlap, drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        base_i    = n_in;
        guard     = 0;
        while (in_ready && guard < 20) begin
            in_a   = $urandom;
            in_b   = $urandom;
            in_cin = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        check("t3_accepts",  64'(n_in - base_i), 64'd4);
        check("t3_in_ready", 64'(in_ready),      64'd0);
        check("t3_valid",    64'(out_valid),     64'd1);
        held = {out_cout, out_ovf, out_sum};
        repeat (5) step();
        check("t3_hold",       64'({out_cout, out_ovf, out_sum}), 64'(held));
        check("t3_still_full", 64'(n_in - base_i),                64'd4);
        out_ready = 1'b1;
        step();
        check("t3_occupancy", 64'(sb.size()),      64'd4);
        check("t3_both_fire", 64'(n_in - base_i),  64'd5);
        in_valid = 1'b0;
        base_o   = n_out;
        guard    = 0;
        while (sb.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
        check("t3_drained", 64'(n_out - base_o), 64'd4);
        check("t3_empty",   64'(sb.size()),      64'd0);

        // 4: random valid/ready traffic
        base_i  = n_in;
        base_o  = n_out;
        guard   = 0;
        pending = 1'b0;
        while ((n_in - base_i) < 1000 && guard < 20000) begin
            if (!pending) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = $urandom;
                in_b     = $urandom;
                in_cin   = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            prev = n_in;
            step();
            guard++;
            pending = in_valid && (n_in == prev);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while (sb.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
        check("t4_in",    64'(n_in - base_i),  64'd1000);
        check("t4_out",   64'(n_out - base_o), 64'd1000);
        check("t4_empty", 64'(sb.size()),      64'd0);

        // 5: reset with operations in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a   = $urandom;
            in_b   = $urandom;
            in_cin = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        step();
        check("t5_in_flight", 64'(sb.size()),  64'd3);
        check("t5_pre_valid", 64'(out_valid),  64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_sum",   64'(out_sum),   64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_wait(32'd5, 32'd7, 1'b1, got);
        check("t5_sum",  64'(got[WIDTH-1:0]), 64'd13);
        check("t5_cout", 64'(got[WIDTH+1]),   64'd0);

        // 6: signed overflow corners
        send_wait(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, got);
        check("t6a_sum",  64'(got[WIDTH-1:0]), 64'h8000_0000);
        check("t6a_cout", 64'(got[WIDTH+1]),   64'd0);
`ifdef PIPE_ADD_OVF_EN
        check("t6a_ovf",  64'(got[WIDTH]),     64'd1);
`else
        check("t6a_ovf",  64'(got[WIDTH]),     64'd0);
`endif
        send_wait(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, got);
        check("t6b_sum",  64'(got[WIDTH-1:0]), 64'h7FFF_FFFF);
        check("t6b_cout", 64'(got[WIDTH+1]),   64'd1);
`ifdef PIPE_ADD_OVF_EN
        check("t6b_ovf",  64'(got[WIDTH]),     64'd1);
`else
        check("t6b_ovf",  64'(got[WIDTH]),     64'd0);
`endif
        check("final_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipelined_rca_adder
